// File: rtl/logic_unit_pkg.sv
// Opcode encoding shared by the logic unit and later ALU blocks.
package logic_unit_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_NOT   = 4'd2;
   localparam logic [3:0] OP_NAND  = 4'd3;
   localparam logic [3:0] OP_NOR   = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_XNOR  = 4'd6;
   localparam logic [3:0] OP_PASSB = 4'd7;
   localparam logic [3:0] OP_LAST  = OP_PASSB;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation selected by a 4-bit opcode.
// Illegal opcodes return zero and raise err_o.
module logic_op_core #(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o,
   output logic             err_o
);
   import logic_unit_pkg::*;

   always_comb begin
      y_o   = '0;
      err_o = !op_legal(op_i);
      case (op_i)
         OP_AND:   y_o = a_i & b_i;
         OP_OR:    y_o = a_i | b_i;
         OP_NOT:   y_o = ~a_i;
         OP_NAND:  y_o = ~(a_i & b_i);
         OP_NOR:   y_o = ~(a_i | b_i);
         OP_XOR:   y_o = a_i ^ b_i;
         OP_XNOR:  y_o = ~(a_i ^ b_i);
         OP_PASSB: y_o = b_i;
         default:  y_o = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise unit with chaining accumulator; 2-cycle latency.
// valid/ready both sides, in_ready is combinational from out_ready (no skid), full rate when unstalled.
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   input  logic             acc_wr,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic             err,
   output logic [WIDTH-1:0] acc
);
   import logic_unit_pkg::*;

   typedef struct packed {
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             use_acc;
      logic             acc_wr;
   } s1_t;

   s1_t              s1_q, s1_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s2_load;
   logic             s2_adv;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_y;
   logic             core_err;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s2_adv   = s2_load && s1_valid_q;
   assign in_ready = !s1_valid_q || s2_load;

   // acc is read as the entry leaves S1, so a preceding acc_wr op has already landed.
   assign core_a = s1_q.use_acc ? acc_q : s1_q.a;

   logic_op_core #(.WIDTH(WIDTH)) u_core (
      .op_i  (s1_q.op),
      .a_i   (core_a),
      .b_i   (s1_q.b),
      .y_o   (core_y),
      .err_o (core_err)
   );

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      err_d      = err_q;
      acc_d      = acc_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.op      = op;
            s1_d.a       = a;
            s1_d.b       = b;
            s1_d.use_acc = use_acc;
            s1_d.acc_wr  = acc_wr;
         end
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d   = core_y;
            err_d = core_err;
         end
      end

      if (acc_clr) begin
         acc_d = '0;
      end else if (s2_adv && s1_q.acc_wr && !core_err) begin
         acc_d = core_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         err_q      <= 1'b0;
         acc_q      <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         err_q      <= err_d;
         acc_q      <= acc_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign zero      = (y_q == '0);
   assign parity    = ^y_q;
   assign err       = err_q;
   assign acc       = acc_q;

endmodule
